// File: rtl/ascon_bdi_packer_pkg.sv
// Shared Ascon configuration: default core word width and the segment type encoding.
// D_INVALID is the value shown on an idle output.
package ascon_bdi_packer_pkg;

    localparam int CCW = 32;

    typedef enum logic [2:0] {
        D_INVALID = 3'd0,
        D_NONCE   = 3'd1,
        D_AD      = 3'd2,
        D_MSG     = 3'd3,
        D_TAG     = 3'd4
    } data_e;

endpackage

// File: rtl/ascon_bdi_packer_if.sv
// Byte-stream input and core bdi word output of the packer, plus the sticky error flag.
// slave = packer side, master = environment side.
interface ascon_bdi_packer_if #(
    parameter int CCW = ascon_bdi_packer_pkg::CCW
);
    import ascon_bdi_packer_pkg::*;

    localparam int NB = CCW / 8;

    logic [7:0]     s_data;
    logic           s_valid;
    logic           s_ready;
    data_e          s_type;
    logic           s_last;
    logic           s_eoi;

    logic [CCW-1:0] bdi;
    logic [NB-1:0]  bdi_valid;
    logic           bdi_ready;
    data_e          bdi_type;
    logic           bdi_eot;
    logic           bdi_eoi;

    logic           err;

    modport slave (
        input  s_data, s_valid, s_type, s_last, s_eoi, bdi_ready,
        output s_ready, bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi, err
    );

    modport master (
        output s_data, s_valid, s_type, s_last, s_eoi, bdi_ready,
        input  s_ready, bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi, err
    );

endinterface

// File: rtl/ascon_word_fifo.sv
// Two-entry word FIFO; a pushed word is readable the cycle after the push edge.
// push_rdy is a flop (occupancy < 2), so it has no combinational path from pop.
module ascon_word_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    input  logic         pop,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        do_push = push && push_rdy;
        do_pop  = pop && (cnt != 2'd0);
        cnt_nxt = cnt + 2'(do_push) - 2'(do_pop);
        pop_vld = (cnt != 2'd0);
        pop_dat = pop_vld ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            cnt      <= 2'd0;
            push_rdy <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            cnt      <= cnt_nxt;
            push_rdy <= (cnt_nxt != 2'd2);
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ascon_bdi_packer.sv
// Packs a typed byte stream into CCW-bit bdi words; a closing byte shows on bdi one cycle later.
// s_ready is a registered "FIFO not full"; bdi_ready backpressure only reaches it through occupancy.
module ascon_bdi_packer
    import ascon_bdi_packer_pkg::*;
#(
    parameter int CCW = ascon_bdi_packer_pkg::CCW,
    localparam int NB = CCW / 8
) (
    input  logic               clk,
    input  logic               rst,
    ascon_bdi_packer_if.slave  bus
);

    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef struct packed {
        logic [CCW-1:0] data;
        logic [NB-1:0]  en;
        data_e          typ;
        logic           eot;
        logic           eoi;
    } word_t;

    logic [CW-1:0]  byte_cnt;
    logic [CCW-1:0] acc;
    data_e          acc_type;
    logic           err_q;

    logic           fifo_rdy;
    logic           fifo_vld;
    logic           take;
    logic           mismatch;
    logic           good;
    logic           close;
    logic           push;
    logic           pop;
    logic [CCW-1:0] lanes;
    word_t          push_word;
    word_t          pop_word;

    always_comb begin
        take     = bus.s_valid && fifo_rdy;
        mismatch = (byte_cnt != '0) && (bus.s_type != acc_type);
        good     = take && !mismatch;
        close    = (byte_cnt == CW'(NB - 1)) || bus.s_last;
        push     = good && close;

        lanes = acc;
        lanes[8*byte_cnt +: 8] = bus.s_data;

        push_word      = '0;
        push_word.data = lanes;
        for (int k = 0; k < NB; k++) begin
            push_word.en[k] = (k <= int'(byte_cnt));
        end
        // A good byte mid-word always carries the latched type, so s_type is correct either way.
        push_word.typ = bus.s_type;
        push_word.eot = bus.s_last;
        push_word.eoi = bus.s_last && bus.s_eoi;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt <= '0;
            acc      <= '0;
            acc_type <= D_INVALID;
            err_q    <= 1'b0;
        end else begin
            if (take && mismatch) err_q <= 1'b1;
            if (good) begin
                if (byte_cnt == '0) acc_type <= bus.s_type;
                // Clearing on close keeps unfilled lanes of the next word at zero.
                if (close) begin
                    byte_cnt <= '0;
                    acc      <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    acc      <= lanes;
                end
            end
        end
    end

    ascon_word_fifo #(
        .W($bits(word_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_word),
        .push_rdy (fifo_rdy),
        .pop      (pop),
        .pop_vld  (fifo_vld),
        .pop_dat  (pop_word)
    );

    assign pop           = fifo_vld && bus.bdi_ready;
    assign bus.s_ready   = fifo_rdy;
    assign bus.bdi       = pop_word.data;
    assign bus.bdi_valid = pop_word.en;
    assign bus.bdi_type  = pop_word.typ;
    assign bus.bdi_eot   = pop_word.eot;
    assign bus.bdi_eoi   = pop_word.eoi;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ascon_bdi_packer.sv
// Directed bench for ascon_bdi_packer at CCW=32 with hand-computed expected words.
module tb_ascon_bdi_packer;
    import ascon_bdi_packer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ascon_bdi_packer_if #(.CCW(32)) bus ();

    ascon_bdi_packer #(.CCW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds the byte until accepted (bounded), returns at acceptance edge + 1.
    task automatic send(input logic [7:0] d, input data_e t, input logic l, input logic e);
        int n;
        bus.s_data  = d;
        bus.s_type  = t;
        bus.s_last  = l;
        bus.s_eoi   = e;
        bus.s_valid = 1'b1;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("send_timeout_s_ready", 64'(bus.s_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_eoi   = 1'b0;
    endtask

    // Checks the head word as it stands now, then pops it.
    task automatic get(input string tag, input logic [31:0] d, input logic [3:0] en,
                       input data_e t, input logic eot, input logic eoi);
        chk(tag, 64'({bus.bdi, bus.bdi_valid, bus.bdi_type, bus.bdi_eot, bus.bdi_eoi}),
                 64'({d, en, t, eot, eoi}));
        bus.bdi_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.bdi_ready = 1'b0;
    endtask

    logic [31:0] nonce_w [3];

    initial begin
        nonce_w[0] = 32'h03020100;
        nonce_w[1] = 32'h07060504;
        nonce_w[2] = 32'h0B0A0908;

        bus.s_data    = 8'h00;
        bus.s_valid   = 1'b0;
        bus.s_type    = D_INVALID;
        bus.s_last    = 1'b0;
        bus.s_eoi     = 1'b0;
        bus.bdi_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        chk("reset_s_ready", 64'(bus.s_ready), 64'd1);
        chk("reset_bdi_valid", 64'(bus.bdi_valid), 64'd0);
        chk("reset_bdi_fields", 64'({bus.bdi, bus.bdi_type, bus.bdi_eot, bus.bdi_eoi}), 64'd0);
        chk("reset_err", 64'(bus.err), 64'd0);

        // 12-byte nonce, three full words, eot on the last
        for (int i = 0; i < 12; i++) begin
            send(8'(i), D_NONCE, (i == 11), 1'b0);
            if (i % 4 == 3) get($sformatf("nonce_w%0d", i / 4), nonce_w[i / 4], 4'hF,
                                D_NONCE, (i == 11), 1'b0);
        end
        chk("idle_after_nonce", 64'({bus.bdi_valid, bus.bdi, bus.bdi_type, bus.bdi_eot, bus.bdi_eoi}), 64'd0);

        // 5-byte AD: full word then a 1-byte tail word
        send(8'hAA, D_AD, 1'b0, 1'b0);
        send(8'hAB, D_AD, 1'b0, 1'b0);
        send(8'hAC, D_AD, 1'b0, 1'b0);
        send(8'hAD, D_AD, 1'b0, 1'b0);
        get("ad_w0", 32'hADACABAA, 4'hF, D_AD, 1'b0, 1'b0);
        send(8'hAE, D_AD, 1'b1, 1'b0);
        get("ad_tail", 32'h000000AE, 4'h1, D_AD, 1'b1, 1'b0);

        // s_eoi on a non-last byte is ignored
        send(8'hC0, D_TAG, 1'b0, 1'b0);
        send(8'hC1, D_TAG, 1'b0, 1'b1);
        send(8'hC2, D_TAG, 1'b0, 1'b0);
        send(8'hC3, D_TAG, 1'b1, 1'b0);
        get("tag_eoi_ignored", 32'hC3C2C1C0, 4'hF, D_TAG, 1'b1, 1'b0);

        // Backpressure: FIFO fills after 8 bytes, then drains in order
        for (int i = 0; i < 8; i++) send(8'(16 + i), D_MSG, 1'b0, 1'b0);
        chk("full_s_ready", 64'(bus.s_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_s_ready", 64'(bus.s_ready), 64'd0);
        chk("stall_head", 64'(bus.bdi), 64'h13121110);
        get("msg_w0", 32'h13121110, 4'hF, D_MSG, 1'b0, 1'b0);
        chk("drain_s_ready", 64'(bus.s_ready), 64'd1);
        send(8'h18, D_MSG, 1'b0, 1'b0);
        send(8'h19, D_MSG, 1'b0, 1'b0);
        send(8'h1A, D_MSG, 1'b0, 1'b0);
        send(8'h1B, D_MSG, 1'b1, 1'b0);
        chk("refull_s_ready", 64'(bus.s_ready), 64'd0);
        get("msg_w1", 32'h17161514, 4'hF, D_MSG, 1'b0, 1'b0);
        get("msg_w2", 32'h1B1A1918, 4'hF, D_MSG, 1'b1, 1'b0);

        // Type change mid-word: byte dropped, err sticky, packing continues
        send(8'h20, D_AD, 1'b0, 1'b0);
        send(8'h21, D_AD, 1'b0, 1'b0);
        send(8'h22, D_AD, 1'b0, 1'b0);
        chk("pre_mismatch_err", 64'(bus.err), 64'd0);
        send(8'h99, D_MSG, 1'b0, 1'b0);
        chk("mismatch_err", 64'(bus.err), 64'd1);
        chk("mismatch_no_word", 64'(bus.bdi_valid), 64'd0);
        send(8'h23, D_AD, 1'b1, 1'b0);
        get("ad_after_err", 32'h23222120, 4'hF, D_AD, 1'b1, 1'b0);
        chk("err_sticky", 64'(bus.err), 64'd1);

        // Reset with one word queued and byte_cnt=3
        for (int i = 0; i < 7; i++) send(8'(48 + i), D_MSG, 1'b0, 1'b0);
        chk("queued_word", 64'(bus.bdi_valid), 64'hF);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst2_bdi_valid", 64'(bus.bdi_valid), 64'd0);
        chk("rst2_s_ready", 64'(bus.s_ready), 64'd1);
        chk("rst2_err", 64'(bus.err), 64'd0);
        send(8'h77, D_MSG, 1'b1, 1'b0);
        get("rst2_lane0", 32'h00000077, 4'h1, D_MSG, 1'b1, 1'b0);

        // Single-byte final segment
        send(8'h5A, D_MSG, 1'b1, 1'b1);
        get("single_eoi", 32'h0000005A, 4'h1, D_MSG, 1'b1, 1'b1);
        chk("final_idle", 64'({bus.bdi_valid, bus.bdi, bus.bdi_type, bus.bdi_eot, bus.bdi_eoi}), 64'd0);
        chk("final_err", 64'(bus.err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
